// File: rtl/clk_div_multi_if.sv
// Control/status bundle for clk_div_multi: divisor config, run/sync
// requests in, divided clocks, ticks and run status out.
interface clk_div_multi_if #(
    parameter int CH = 4,
    parameter int DW = 16
);
    localparam int CW = (CH > 1) ? $clog2(CH) : 1;

    logic          cfg_we;
    logic [CW-1:0] cfg_ch;
    logic [DW-1:0] cfg_div;
    logic [CH-1:0] en;
    logic          sync;
    logic [CH-1:0] clk_out;
    logic [CH-1:0] tick;
    logic [CH-1:0] running;

    modport master (
        output cfg_we, cfg_ch, cfg_div, en, sync,
        input  clk_out, tick, running
    );

    modport slave (
        input  cfg_we, cfg_ch, cfg_div, en, sync,
        output clk_out, tick, running
    );
endinterface

// File: rtl/clk_div_multi.sv
// Multi-channel counter-based clock divider. Each channel runs its own
// IDLE/RUN/STOP machine; enable changes only take effect on period
// boundaries so clk_out never emits a runt pulse.

// One divider channel.
module clk_div_ch #(
    parameter int DW      = 16,
    parameter int DIV_RST = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr,       // divisor write for this channel
    input  logic [DW-1:0] wdiv,     // already clamped to >= 2
    input  logic          en,
    input  logic          sync,
    output logic          clk_out,
    output logic          tick,
    output logic          running
);
    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

    state_t        state, state_nx;
    logic [DW-1:0] cnt, cnt_nx;
    logic [DW-1:0] div_cfg, div_cfg_nx;
    logic [DW-1:0] div_act, div_act_nx;
    logic          bnd;
    logic          clk_out_nx, tick_nx, running_nx;

    // Next-state: sync overrides the normal enable-driven FSM. A write
    // landing on a boundary flows straight into div_act for the next period.
    always_comb begin
        div_cfg_nx = wr ? wdiv : div_cfg;
        bnd        = (cnt == div_act - DW'(1));
        state_nx   = state;
        cnt_nx     = cnt;
        div_act_nx = div_act;

        if (sync && state == RUN) begin
            cnt_nx     = '0;
            div_act_nx = div_cfg_nx;
        end else if (sync && state == STOP) begin
            state_nx   = IDLE;
            cnt_nx     = '0;
            div_act_nx = div_cfg_nx;
        end else begin
            case (state)
                RUN, STOP: begin
                    cnt_nx = bnd ? '0 : cnt + DW'(1);
                    if (bnd) div_act_nx = div_cfg_nx;
                    if (en)       state_nx = RUN;
                    else if (state == RUN) state_nx = STOP;
                    else if (bnd) state_nx = IDLE;
                end
                default: begin
                    // idle: counter parked, divisor tracks config continuously
                    cnt_nx     = '0;
                    div_act_nx = div_cfg_nx;
                    if (en) state_nx = RUN;
                end
            endcase
        end

        running_nx = (state_nx != IDLE);
        clk_out_nx = running_nx && (cnt_nx < (div_act_nx >> 1));
        tick_nx    = running_nx && (cnt_nx == '0);
    end

    // State, divisors and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            div_cfg <= DW'(DIV_RST);
            div_act <= DW'(DIV_RST);
            clk_out <= 1'b0;
            tick    <= 1'b0;
            running <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            div_cfg <= div_cfg_nx;
            div_act <= div_act_nx;
            clk_out <= clk_out_nx;
            tick    <= tick_nx;
            running <= running_nx;
        end
    end
endmodule

module clk_div_multi #(
    parameter int CH      = 4,
    parameter int DW      = 16,
    parameter int DIV_RST = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    clk_div_multi_if.slave bus
);
    logic [DW-1:0] wdiv;
    logic [CH-1:0] wr, co, tk, rn;

    // divisors below 2 are meaningless for a toggling output
    assign wdiv = (bus.cfg_div < DW'(2)) ? DW'(2) : bus.cfg_div;

    // Out-of-range channel indices match no lane and are dropped.
    for (genvar i = 0; i < CH; i++) begin : g_ch
        assign wr[i] = bus.cfg_we && (int'(bus.cfg_ch) == i);

        clk_div_ch #(.DW(DW), .DIV_RST(DIV_RST)) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr      (wr[i]),
            .wdiv    (wdiv),
            .en      (bus.en[i]),
            .sync    (bus.sync),
            .clk_out (co[i]),
            .tick    (tk[i]),
            .running (rn[i])
        );
    end

    assign bus.clk_out = co;
    assign bus.tick    = tk;
    assign bus.running = rn;
endmodule
